// File: rtl/bus_timer_pkg.sv
// Shared constants and types for the bus_timer peripheral: register word
// indices (addr[4:2]), CTRL bit layout and the interconnect region code.
package bus_timer_pkg;

  // Word index of each register, compared against addr[4:2].
  localparam logic [2:0] OFF_CTRL     = 3'd0;  // byte offset 0x00
  localparam logic [2:0] OFF_PRESCALE = 3'd1;  // byte offset 0x04
  localparam logic [2:0] OFF_COUNT    = 3'd2;  // byte offset 0x08
  localparam logic [2:0] OFF_COMPARE  = 3'd3;  // byte offset 0x0C
  localparam logic [2:0] OFF_STATUS   = 3'd4;  // byte offset 0x10

  // CTRL bit positions.
  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_AUTO_RELOAD_BIT = 1;
  localparam int CTRL_IRQ_EN_BIT      = 2;
  localparam int CTRL_BITS            = 3;

  // addr[31:28] value the interconnect uses to select this peripheral.
  localparam logic [3:0] REGION_TIMER = 4'd3;

  // Packed so that enable lands on bit 0 and irq_en on bit 2.
  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic enable;
  } ctrl_t;

endpackage

// File: rtl/bus_timer_if.sv
// Responder-side data bus bundle for bus_timer: address, write data,
// decoded write enable, registered read data and the interrupt line.
interface bus_timer_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] addr;
  logic [WIDTH-1:0] wdata;
  logic             we;
  logic [WIDTH-1:0] rdata;
  logic             irq;

  modport master (
    output addr,
    output wdata,
    output we,
    input  rdata,
    input  irq
  );

  modport slave (
    input  addr,
    input  wdata,
    input  we,
    output rdata,
    output irq
  );
endinterface

// File: rtl/bus_timer_prescaler.sv
// Prescaler for bus_timer: while enabled, counts 0..preset and emits a
// one-cycle tick on the cycle the count equals preset, then restarts at 0.
module timer_prescaler #(
  parameter int PRESC_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_enable,
  input  logic [PRESC_WIDTH-1:0] i_preset,
  input  logic                   i_clear,
  output logic                   o_tick
);

  logic [PRESC_WIDTH-1:0] r_cnt;
  logic                   w_at_end;

  assign w_at_end = (r_cnt == i_preset);
  // The tick reflects the pre-edge count, so a clear landing on a tick
  // cycle still lets that tick through.
  assign o_tick   = i_enable && w_at_end;

  // Count while enabled, hold while disabled; a clear restarts the period.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable) begin
      if (w_at_end) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped timer/compare peripheral: register file, prescaled
// up-counter, compare match with optional auto-reload, sticky W1C match
// flag and level interrupt. Read data is registered (one cycle latency).
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int PRESC_WIDTH = 16
) (
  input  logic          clk,
  input  logic          rst,
  bus_timer_if.slave    bus
);

  logic [2:0]             w_sel;
  logic                   w_wr_ctrl;
  logic                   w_wr_presc;
  logic                   w_wr_count;
  logic                   w_wr_compare;
  logic                   w_wr_status;
  logic                   w_tick;
  logic                   w_hit;
  logic [WIDTH-1:0]       w_rd_mux;
  logic                   w_unused_addr;

  ctrl_t                  r_ctrl;
  logic [PRESC_WIDTH-1:0] r_prescale;
  logic [WIDTH-1:0]       r_count;
  logic [WIDTH-1:0]       r_compare;
  logic                   r_match;
  logic [WIDTH-1:0]       r_rdata;

  // Only addr[4:2] selects a register; the rest of the address is ignored.
  assign w_sel         = bus.addr[4:2];
  assign w_unused_addr = ^{bus.addr[WIDTH-1:5], bus.addr[1:0]};

  assign w_wr_ctrl    = bus.we && (w_sel == OFF_CTRL);
  assign w_wr_presc   = bus.we && (w_sel == OFF_PRESCALE);
  assign w_wr_count   = bus.we && (w_sel == OFF_COUNT);
  assign w_wr_compare = bus.we && (w_sel == OFF_COMPARE);
  assign w_wr_status  = bus.we && (w_sel == OFF_STATUS);

  // Compare always uses the pre-write COUNT and COMPARE values.
  assign w_hit = w_tick && (r_count == r_compare);

  timer_prescaler #(
    .PRESC_WIDTH (PRESC_WIDTH)
  ) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .i_enable (r_ctrl.enable),
    .i_preset (r_prescale),
    .i_clear  (w_wr_presc),
    .o_tick   (w_tick)
  );

  // Configuration registers: CTRL, PRESCALE, COMPARE.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ctrl     <= '0;
      r_prescale <= '0;
      r_compare  <= '1;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= ctrl_t'(bus.wdata[CTRL_BITS-1:0]);
      end
      if (w_wr_presc) begin
        r_prescale <= bus.wdata[PRESC_WIDTH-1:0];
      end
      if (w_wr_compare) begin
        r_compare <= bus.wdata;
      end
    end
  end

  // COUNT: a bus write beats the tick; on a match, reload to 0 or keep counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (w_wr_count) begin
      r_count <= bus.wdata;
    end else if (w_tick) begin
      if (w_hit && r_ctrl.auto_reload) begin
        r_count <= '0;
      end else begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  // Sticky match flag: a set on this edge wins over a simultaneous W1C.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_match <= 1'b0;
    end else if (w_hit) begin
      r_match <= 1'b1;
    end else if (w_wr_status && bus.wdata[0]) begin
      r_match <= 1'b0;
    end
  end

  // Read multiplexer over the current (pre-write) register state.
  always_comb begin
    w_rd_mux = '0;
    case (w_sel)
      OFF_CTRL:     w_rd_mux = {{(WIDTH-CTRL_BITS){1'b0}}, r_ctrl};
      OFF_PRESCALE: w_rd_mux = {{(WIDTH-PRESC_WIDTH){1'b0}}, r_prescale};
      OFF_COUNT:    w_rd_mux = r_count;
      OFF_COMPARE:  w_rd_mux = r_compare;
      OFF_STATUS:   w_rd_mux = {{(WIDTH-1){1'b0}}, r_match};
      default:      w_rd_mux = '0;
    endcase
  end

  // Register read data every cycle, independent of we.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= w_rd_mux;
    end
  end

  assign bus.rdata = r_rdata;
  assign bus.irq   = r_match & r_ctrl.irq_en;

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer. Drivers push the expected read data
// and irq level into a scoreboard queue when a read is issued; a separate
// monitor pops and compares one cycle later, on the falling edge.
module tb_bus_timer;
  import bus_timer_pkg::*;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        irq;
  } exp_t;

  logic clk;
  logic rst;
  logic rd_issue;
  int   n_tests;
  int   n_fail;
  exp_t sb[$];

  bus_timer_if #(.WIDTH(32)) bus ();

  bus_timer #(
    .WIDTH       (32),
    .PRESC_WIDTH (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [31:0] A_CTRL    = 32'h3000_0000;
  localparam logic [31:0] A_PRESC   = 32'h3000_0004;
  localparam logic [31:0] A_COUNT   = 32'h3000_0008;
  localparam logic [31:0] A_COMPARE = 32'h3000_000C;
  localparam logic [31:0] A_STATUS  = 32'h3000_0010;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each task occupies exactly one rising edge.
  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.we    = 1'b1;
    rd_issue  = 1'b0;
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, input logic [31:0] exp_d,
                          input logic exp_irq, input string nm);
    exp_t e;
    e.name  = nm;
    e.rdata = exp_d;
    e.irq   = exp_irq;
    bus.addr = a;
    bus.we   = 1'b0;
    sb.push_back(e);
    rd_issue = 1'b1;
    @(posedge clk);
    #1;
    rd_issue = 1'b0;
  endtask

  task automatic pulse_reset(input logic with_write);
    rst = 1'b1;
    if (with_write) begin
      bus.addr  = A_COMPARE;
      bus.wdata = 32'h0000_0007;
      bus.we    = 1'b1;
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bus.we = 1'b0;
  endtask

  // Monitor: a read issued at an edge has its data checked at the next negedge.
  initial begin : monitor
    logic pend;
    exp_t e;
    forever begin
      @(posedge clk);
      pend = rd_issue;
      @(negedge clk);
      if (pend) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard_empty: read completed with no expectation queued");
        end else begin
          e = sb.pop_front();
          n_tests++;
          if (bus.rdata !== e.rdata) begin
            n_fail++;
            $display("FAIL %s rdata: got 0x%08h expected 0x%08h", e.name, bus.rdata, e.rdata);
          end
          n_tests++;
          if (bus.irq !== e.irq) begin
            n_fail++;
            $display("FAIL %s irq: got %0b expected %0b", e.name, bus.irq, e.irq);
          end
          $display("[TB] %s addr=0x%08h rdata=0x%08h irq=%0b", e.name, bus.addr, bus.rdata, bus.irq);
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] reset_vals [8];
    int t;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b1;
    rd_issue = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.we    = 1'b0;
    reset_vals = '{32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset values at every offset
    for (int i = 0; i < 8; i++)
      bus_read(32'h3000_0000 + 32'(i * 4), reset_vals[i], 1'b0, $sformatf("reset_off%0d", i * 4));

    // 2: prescale 3, compare 5, enable + irq_en, no reload
    pulse_reset(1'b0);
    bus_write(A_PRESC, 32'd3);
    bus_write(A_COMPARE, 32'd5);
    bus_write(A_CTRL, 32'b101);
    for (int j = 1; j <= 26; j++)
      bus_read(A_COUNT, 32'((j - 1) / 4), (j >= 24), $sformatf("noreload_j%0d", j));

    // 3: same with auto_reload, then W1C
    pulse_reset(1'b0);
    bus_write(A_PRESC, 32'd3);
    bus_write(A_COMPARE, 32'd5);
    bus_write(A_CTRL, 32'b111);
    for (int j = 1; j <= 30; j++) begin
      t = (j - 1) / 4;
      bus_read(A_COUNT, 32'((t <= 5) ? t : t - 6), (j >= 24), $sformatf("reload_j%0d", j));
    end
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, 32'd0, 1'b0, "w1c_clear");

    // 4: wrap from all-ones to zero without a match
    pulse_reset(1'b0);
    bus_write(A_COUNT, 32'hFFFF_FFFE);
    bus_write(A_PRESC, 32'd0);
    bus_write(A_COMPARE, 32'h10);
    bus_write(A_CTRL, 32'b001);
    bus_read(A_COUNT, 32'hFFFF_FFFE, 1'b0, "wrap_0");
    bus_read(A_COUNT, 32'hFFFF_FFFF, 1'b0, "wrap_1");
    bus_read(A_COUNT, 32'h0000_0000, 1'b0, "wrap_2");
    bus_read(A_COUNT, 32'h0000_0001, 1'b0, "wrap_3");
    bus_read(A_STATUS, 32'd0, 1'b0, "wrap_nomatch");

    // 5a: COUNT write on a tick cycle loads without increment
    pulse_reset(1'b0);
    bus_write(A_PRESC, 32'd1);
    bus_write(A_CTRL, 32'b001);
    bus_read(A_COUNT, 32'd0, 1'b0, "wrtick_0");
    bus_read(A_COUNT, 32'd0, 1'b0, "wrtick_1");
    bus_read(A_COUNT, 32'd1, 1'b0, "wrtick_2");
    bus_write(A_COUNT, 32'h100);
    bus_read(A_COUNT, 32'h100, 1'b0, "wrtick_load");
    bus_read(A_COUNT, 32'h100, 1'b0, "wrtick_hold");
    bus_read(A_COUNT, 32'h101, 1'b0, "wrtick_next");

    // 5b: W1C on the match edge loses; then irq_en masks irq only
    pulse_reset(1'b0);
    bus_write(A_COMPARE, 32'd2);
    bus_write(A_CTRL, 32'b101);
    bus_read(A_COUNT, 32'd0, 1'b0, "w1cset_0");
    bus_read(A_COUNT, 32'd1, 1'b0, "w1cset_1");
    bus_write(A_STATUS, 32'd1);
    bus_read(A_STATUS, 32'd1, 1'b1, "w1cset_sticky");
    bus_write(A_CTRL, 32'b001);
    bus_read(A_STATUS, 32'd1, 1'b0, "irq_masked");

    // 6: reset mid-count, with a write on the reset edge
    pulse_reset(1'b0);
    bus_write(A_COUNT, 32'h40);
    bus_write(A_CTRL, 32'b001);
    bus_read(A_COUNT, 32'h40, 1'b0, "prerst_0");
    bus_read(A_COUNT, 32'h41, 1'b0, "prerst_1");
    pulse_reset(1'b1);
    for (int i = 0; i < 8; i++)
      bus_read(32'h3000_0000 + 32'(i * 4), reset_vals[i], 1'b0, $sformatf("midrst_off%0d", i * 4));
    bus_read(A_COUNT, 32'd0, 1'b0, "midrst_hold");

    repeat (3) @(posedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
Name: bus_timer

Overview:
- Memory-mapped 32-bit timer/compare peripheral.
- It is the responder end of the core data bus. It receives the address, the write data and a decoded write enable from the bus interconnect, which selects it by region 4'd3, addr[31:28].
- It returns read data with exactly one cycle of latency, which matches the interconnect's registered read-data select.
- It provides a prescaled up-counter, a compare match with optional auto-reload, a sticky match flag and a level interrupt.

Parameters:
- WIDTH, 32, bus data/address width; the count and compare registers are WIDTH bits.
- PRESC_WIDTH, 16, width of the prescaler register and the prescaler counter.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset; synchronous, active-high.
- addr  input  WIDTH  bus address; only addr[4:2] is decoded, upper bits are ignored.
- wdata  input  WIDTH  bus write data.
- we  input  1  write enable, already qualified by the interconnect region decode.
- rdata  output  WIDTH  read data, registered, valid the cycle after addr is presented.
- irq  output  1  interrupt, level, = status.match & ctrl.irq_en.

Behaviour:
- Register map (word offsets):
  - 0x00 CTRL: [0] enable, [1] auto_reload, [2] irq_en; other bits read 0.
  - 0x04 PRESCALE: [PRESC_WIDTH-1:0].
  - 0x08 COUNT.
  - 0x0C COMPARE.
  - 0x10 STATUS: [0] match, write-1-to-clear.
  - 0x14–0x1C unmapped: read 0, writes ignored.
- Writes: full word only, no byte enables. They take effect at the clk edge where we=1.
- Reads: no side effects.
  - rdata <= mux(addr[4:2]) every cycle, regardless of we.
  - Read-after-write to the same register in consecutive cycles returns the new value.
  - A read in the same cycle as the write returns the old value.
- Reset values: CTRL=0, PRESCALE=0, COUNT=0, COMPARE=all-ones, STATUS=0, prescaler counter=0, rdata=0, irq=0.
- Prescaler:
  - When enable=1, presc_cnt increments each cycle.
  - When presc_cnt==PRESCALE, a tick is generated and presc_cnt <= 0.
  - PRESCALE=0 therefore ticks every cycle; PRESCALE=N ticks every N+1 cycles.
  - When enable=0, presc_cnt and COUNT hold.
  - Writing PRESCALE forces presc_cnt <= 0 in the same edge.
- Counter on tick:
  - If COUNT==COMPARE: STATUS.match <= 1, and COUNT <= auto_reload ? 0 : COUNT+1.
  - Otherwise COUNT <= COUNT+1.
  - The add is mod 2^WIDTH, so COUNT wraps from all-ones to 0 with no flag unless COMPARE matches.
- Priority rules for simultaneous events:
  - A bus write to COUNT beats a tick update; the written value is loaded and no increment occurs that cycle.
  - The match compare uses the pre-write COUNT.
  - A bus write to COMPARE takes effect for the next tick.
  - A STATUS W1C in the same cycle as a match set: the set wins, and match stays 1.
  - Clearing CTRL.enable mid-period freezes presc_cnt; re-enabling resumes without reset.
- irq is combinational from registered state, so it rises in the cycle after the match edge. Clearing irq_en masks irq without clearing match.
- rst asserted mid-count returns every register to its reset value at that edge. A write in the same cycle as rst is discarded.

Decomposition:
- Package bus_timer_pkg:
  - Register offset constants: OFF_CTRL, OFF_PRESCALE, OFF_COUNT, OFF_COMPARE, OFF_STATUS.
  - CTRL bit indices.
  - Packed struct ctrl_t {irq_en, auto_reload, enable}.
  - REGION_TIMER = 4'd3, for the interconnect decode.
- One natural sub-module, timer_prescaler: inputs enable, preset value, clear; output tick. The register file, counter and compare stay in bus_timer.

Test Plan:
- Reset, then read each offset 0x00–0x1C → rdata one cycle later: 0, 0, 0, 0xFFFFFFFF, 0, 0, 0, 0; irq=0.
- PRESCALE=3, COMPARE=5, CTRL=0b101 (enable, irq_en):
  - COUNT increments every 4 cycles.
  - match and irq rise in the cycle after the tick at which COUNT==5.
  - COUNT continues to 6 (no auto_reload).
- Same setup with CTRL=0b111 (adds auto_reload) → COUNT sequence 0..5,0,1…; writing STATUS=1 clears match and irq next cycle.
- COUNT=0xFFFFFFFE, PRESCALE=0, COMPARE=0x10, enable → COUNT reads 0xFFFFFFFF then 0x00000000; match stays 0.
- Simultaneous events:
  - A COUNT=0x100 write on a tick cycle → 0x100 is loaded with no increment.
  - A STATUS W1C on a match cycle → match remains 1.
- rst pulse while COUNT=0x42 and enable=1 → all registers read their reset values; COUNT stays 0 afterwards until re-enabled.
